// File: rtl/sync_filter_edge.sv
// sync_filter_edge: per-channel N-flop synchroniser, optional glitch filter and rise/fall/any-change pulses
//   clk        clock
//   rst_n      asynchronous active-low reset
//   Async_Bits asynchronous inputs, one per channel
//   Sync_Bits  synchronised (and filtered) levels
//   Rise_Pulse one-cycle pulse on each 0->1 of Sync_Bits
//   Fall_Pulse one-cycle pulse on each 1->0 of Sync_Bits
//   Any_Change OR of all rise and fall pulses
module sync_filter_edge #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH = 4,
  parameter logic [BUS_WIDTH-1:0] RST_VAL = {BUS_WIDTH{1'b0}},
  parameter int FILTER_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] Async_Bits,
  output logic [BUS_WIDTH-1:0] Sync_Bits,
  output logic [BUS_WIDTH-1:0] Rise_Pulse,
  output logic [BUS_WIDTH-1:0] Fall_Pulse,
  output logic                 Any_Change
);
  logic [BUS_WIDTH-1:0] raw, filt, prev;
  if (NUM_STAGES < 2) begin : g_bad
    $error("sync_filter_edge: NUM_STAGES must be >= 2");
  end
  for (genvar g = 0; g < BUS_WIDTH; g++) begin : g_ch
    logic [NUM_STAGES-1:0] st;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= {NUM_STAGES{RST_VAL[g]}};
      else st <= {st[NUM_STAGES-2:0], Async_Bits[g]};
    assign raw[g] = st[NUM_STAGES-1];
    if (FILTER_CYCLES == 0) begin : g_byp
      assign filt[g] = raw[g];
    end else begin : g_flt
      localparam int CW = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
      logic f;
      logic [CW-1:0] cnt;
      // cnt counts consecutive cycles raw has disagreed with the accepted level
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          f <= RST_VAL[g];
          cnt <= '0;
        end else if (raw[g] == f) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          f <= raw[g];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      assign filt[g] = f;
    end
  end
  // history resets to RST_VAL so neither reset edge can produce a pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= RST_VAL;
    else prev <= filt;
  assign Sync_Bits = filt;
  assign Rise_Pulse = filt & ~prev;
  assign Fall_Pulse = ~filt & prev;
  assign Any_Change = |(Rise_Pulse | Fall_Pulse);
endmodule

// File: tb/tb_sync_filter_edge.sv
// tb_sync_filter_edge: directed table-driven bench for filtered and bypass builds
module tb_sync_filter_edge;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] a_in = 4'b1010;
  logic [3:0] b_in = 4'b0000;
  logic [3:0] sync_a, rise_a, fall_a, sync_b, rise_b, fall_b;
  logic any_a, any_b;
  int passed = 0;
  int total = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [12:0] e;
  } vec_t;
  vec_t tv[$];

  sync_filter_edge #(.NUM_STAGES(2), .BUS_WIDTH(4), .RST_VAL(4'b0101), .FILTER_CYCLES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .Async_Bits(a_in), .Sync_Bits(sync_a),
    .Rise_Pulse(rise_a), .Fall_Pulse(fall_a), .Any_Change(any_a));

  sync_filter_edge #(.NUM_STAGES(3), .BUS_WIDTH(4), .RST_VAL(4'b0000), .FILTER_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .Async_Bits(b_in), .Sync_Bits(sync_b),
    .Rise_Pulse(rise_b), .Fall_Pulse(fall_b), .Any_Change(any_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got sync/rise/fall/any=%b_%b_%b_%b required %b_%b_%b_%b", name,
                  got[12:9], got[8:5], got[4:1], got[0], exp[12:9], exp[8:5], exp[4:1], exp[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic [3:0] a, input logic [3:0] s,
                     input logic [3:0] r, input logic [3:0] f, input logic an);
    for (int i = 0; i < n; i++) tv.push_back('{a, {s, r, f, an}});
  endtask

  initial begin
    // clean rise of bit1: visible after the fifth edge
    add(4, 4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0111, 4'b0111, 4'b0010, 4'b0000, 1'b1);
    add(2, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
    // bit3 high for 2 cycles: filtered out
    add(2, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
    add(6, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
    // bit3 high for 3 cycles: accepted, then the return low is accepted too
    add(3, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0111, 4'b1111, 4'b1000, 4'b0000, 1'b1);
    add(2, 4'b0111, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0111, 4'b0111, 4'b0000, 4'b1000, 1'b1);
    add(2, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
    // bit2 down to prepare the simultaneous case
    add(4, 4'b0011, 4'b0111, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0011, 4'b0011, 4'b0000, 4'b0100, 1'b1);
    add(2, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    // bit0 falls and bit2 rises on the same edge
    add(4, 4'b0110, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0110, 4'b0110, 4'b0100, 4'b0001, 1'b1);
    add(2, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 1'b0);

    #1 rst_n = 1'b0;
    #1 chk("reset_async_a", {sync_a, rise_a, fall_a, any_a}, {4'b0101, 4'b0000, 4'b0000, 1'b0});
    chk("reset_async_b", {sync_b, rise_b, fall_b, any_b}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
    tick();
    tick();
    chk("reset_held_a", {sync_a, rise_a, fall_a, any_a}, {4'b0101, 4'b0000, 4'b0000, 1'b0});
    a_in = 4'b0101;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle_%0d", i), {sync_a, rise_a, fall_a, any_a}, {4'b0101, 4'b0000, 4'b0000, 1'b0});
    end

    for (int i = 0; i < tv.size(); i++) begin
      a_in = tv[i].a;
      tick();
      chk($sformatf("vec_%0d", i), {sync_a, rise_a, fall_a, any_a}, tv[i].e);
    end

    // toggle bit1 and assert reset once its filter counter has reached 2
    a_in = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midfilt_%0d", i), {sync_a, rise_a, fall_a, any_a}, {4'b0110, 4'b0000, 4'b0000, 1'b0});
    end
    rst_n = 1'b0;
    #1 chk("midfilt_reset", {sync_a, rise_a, fall_a, any_a}, {4'b0101, 4'b0000, 4'b0000, 1'b0});
    tick();
    a_in = 4'b0101;
    tick();
    rst_n = 1'b1;
    chk("midfilt_release", {sync_a, rise_a, fall_a, any_a}, {4'b0101, 4'b0000, 4'b0000, 1'b0});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_reset_%0d", i), {sync_a, rise_a, fall_a, any_a}, {4'b0101, 4'b0000, 4'b0000, 1'b0});
    end

    // bypass build: one-cycle pulse on bit0 through a 3-flop chain
    b_in = 4'b0001;
    tick();
    b_in = 4'b0000;
    chk("byp_e1", {sync_b, rise_b, fall_b, any_b}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
    tick();
    chk("byp_e2", {sync_b, rise_b, fall_b, any_b}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
    tick();
    chk("byp_e3", {sync_b, rise_b, fall_b, any_b}, {4'b0001, 4'b0001, 4'b0000, 1'b1});
    tick();
    chk("byp_e4", {sync_b, rise_b, fall_b, any_b}, {4'b0000, 4'b0000, 4'b0001, 1'b1});
    tick();
    chk("byp_e5", {sync_b, rise_b, fall_b, any_b}, {4'b0000, 4'b0000, 4'b0000, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
